// File: rtl/save_tx_buffer.sv
// save_tx_buffer
//
// Byte FIFO feeding a UART transmitter (8N1, LSB first, idle high).
// Bytes from the upstream saving stage are pushed when write and en are
// both high; the transmitter drains the FIFO one frame at a time and runs
// on every clk, independent of en.
//
// Parameters
//   DEPTH        FIFO depth in bytes (power of two, >= 2)
//   CLKS_PER_BIT clk cycles per UART bit (>= 2)
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   en        clock enable qualifying write
//   data_in   byte to push
//   write     push request (effective only with en=1)
//   tx        registered UART serial output
//   count     bytes currently held in the FIFO
//   empty     count == 0
//   full      count == DEPTH
//   overflow  sticky: a push was dropped because the FIFO was full
//   busy      transmitter is not IDLE

module save_tx_buffer #(
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [7:0]               data_in,
  input  logic                     write,
  output logic                     tx,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ---------------------------------------------------------------------
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    head;

  logic push_req;
  logic push;
  logic drop;
  logic pop;

  assign empty = (count == '0);
  assign full  = (count == COUNT_FULL);

  // full is the registered value, so a pop on the same edge does not make
  // room for a push that arrives while full; that push is dropped.
  assign push_req = write & en;
  assign push     = push_req & ~full;
  assign drop     = push_req & full;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // ---------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------
  state_t        state;
  state_t        state_next;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_next;
  logic [7:0]    shift;
  logic [7:0]    shift_next;
  logic          tx_q;
  logic          tx_next;

  assign tx   = tx_q;
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_next;
      timer   <= timer_next;
      bit_idx <= bit_idx_next;
      shift   <= shift_next;
      tx_q    <= tx_next;
    end
  end

  // tx_next is the line level for the state being entered, so the tx
  // flop changes on the same edge as the state and the output is a clean
  // register with no decode glitches. This also gives the one-edge
  // push-to-start latency out of IDLE.
  always_comb begin
    state_next   = state;
    timer_next   = timer;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    tx_next      = 1'b1;
    pop          = 1'b0;

    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (!empty) begin
          pop          = 1'b1;
          shift_next   = head;
          timer_next   = '0;
          bit_idx_next = '0;
          state_next   = START;
          tx_next      = 1'b0;
        end
      end

      START: begin
        if (timer == TIMER_LAST) begin
          timer_next = '0;
          state_next = DATA;
          tx_next    = shift[0];
        end else begin
          timer_next = timer + 1'b1;
          tx_next    = 1'b0;
        end
      end

      DATA: begin
        if (timer == TIMER_LAST) begin
          timer_next = '0;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            tx_next      = shift[bit_idx + 3'd1];
          end
        end else begin
          timer_next = timer + 1'b1;
          tx_next    = shift[bit_idx];
        end
      end

      STOP: begin
        tx_next = 1'b1;
        if (timer == TIMER_LAST) begin
          timer_next = '0;
          state_next = IDLE;
        end else begin
          timer_next = timer + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        timer_next = '0;
        tx_next    = 1'b1;
      end
    endcase
  end

endmodule

// File: doc/save_tx_buffer.md
SAVE_TX_BUFFER -- requirements
Module: save_tx_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning FIFO depth in bytes; it SHALL be a power of two, minimum 2.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200); minimum 2.
REQ-003 The block SHALL have port clk  input  1  system clock; all logic on the rising edge; single clock domain.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port en  input  1  clock-enable qualifying write, same strobe as the upstream saving stage.
REQ-006 The block SHALL have port data_in  input  8  byte from the upstream saving stage (digits or ASCII space).
REQ-007 The block SHALL have port write  input  1  push request; a byte is accepted only when write=1 and en=1.
REQ-008 The block SHALL have port tx  output  1  UART serial line, 8N1, LSB first, idle high.
REQ-009 The block SHALL have port count  output  log2(DEPTH)+1  number of bytes held in the FIFO.
REQ-010 The block SHALL have port empty  output  1  high when count=0.
REQ-011 The block SHALL have port full  output  1  high when count=DEPTH.
REQ-012 The block SHALL have port overflow  output  1  sticky flag: a byte was dropped.
REQ-013 The block SHALL have port busy  output  1  high while the transmitter FSM is not IDLE.

Function
REQ-014 Push SHALL occur at a rising edge where write=1, en=1 and full=0 (registered value before that edge); data_in is stored at the write pointer and count increments.
REQ-015 A push request while full=1 SHALL drop the byte, leave the FIFO unchanged and set overflow=1 from the next edge until reset, even if a pop occurs on the same edge.
REQ-016 write=1 with en=0 SHALL have no effect.
REQ-017 Read and write pointers SHALL wrap modulo DEPTH; simultaneous push and pop SHALL leave count unchanged.
REQ-018 Transmitter FSM states SHALL be IDLE, START, DATA, STOP.
REQ-019 IDLE: tx=1; if empty=0, pop the head byte into a shift register, clear the bit timer and bit index, and go to START on the same edge.
REQ-020 START: tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-021 DATA: tx equals shift bit[index], index 0..7, each held for CLKS_PER_BIT cycles; after bit 7, go to STOP.
REQ-022 STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
REQ-023 tx SHALL be a registered output and glitch-free; a frame is exactly 10*CLKS_PER_BIT cycles low-to-end-of-stop.
REQ-024 Latency: a byte pushed into an empty FIFO with the FSM in IDLE SHALL drive tx low from the first rising edge after the push edge.
REQ-025 Back-to-back: when the FIFO is non-empty at the end of STOP, exactly one IDLE cycle (tx=1) SHALL separate the two frames.
REQ-026 The bit timer SHALL count 0..CLKS_PER_BIT-1 and the bit index SHALL be 3 bits; there SHALL be no other overflow or wrap behaviour.
REQ-027 en SHALL NOT gate the transmitter; the FSM runs on every clk.

Reset
REQ-028 While rst=1, on each edge: pointers=0, count=0, empty=1, full=0, overflow=0, state=IDLE, busy=0, tx=1; rst overrides a concurrent write.
REQ-029 A reset mid-frame SHALL abort the frame (tx=1 after the reset edge) and discard all FIFO contents; there SHALL be no partial-frame resume.

Verification (CLKS_PER_BIT=4, DEPTH=4)
REQ-030 Reset, then one push of 8'h35 -> tx low after the next edge, then the bit sequence 1,0,1,0,1,1,0,0 (4 cycles each), then stop 1; total 40 cycles; busy high throughout.
REQ-031 Push "1","2"," " on consecutive cycles -> count peaks at 2 (first byte pops immediately); three frames, each separated by exactly one idle cycle; empty=1 at the end.
REQ-032 With the FSM held busy, push 6 bytes -> full=1 after the 4th accepted push (count=4); the 5th and 6th bytes are dropped; overflow=1 and stays 1; only 5 frames are sent.
REQ-033 write=1 with en=0 for 10 cycles -> count stays 0, tx stays 1, overflow=0.
REQ-034 Assert rst at cycle 15 of a frame with 2 bytes queued -> tx=1, count=0, busy=0 on the next edge; no further frames are sent.
REQ-035 Push while full on the same edge as an IDLE pop -> the byte is dropped, overflow=1, and count goes from 4 to 3.
